clock_ratio_detector: RTL and testbench

- Measures the high and low phase lengths of a slow incoming clock, counted in `clk` cycles.
- Reports each measured pair and asserts `locked` once the waveform has been stable for a configurable number of periods.
- Sits at the receiving end of a `clk`-derived divided clock. It checks a divider's output ratio, or recovers the ratio of an unknown slow clock from another block.
- `clk_in` is treated as asynchronous.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 33 +++
 rtl/clock_ratio_detector.sv | 170 +++++++++++++++++
 tb/tb_clock_ratio_detector.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types for the clock ratio detector: measurement FSM states,
// lock counter sizing and the debug view of the internal state.
package clock_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int LOCK_CNT_W = 4;

    typedef struct packed {
        state_t                  state;
        logic                    level;
        logic                    have_high;
        logic                    have_low;
        logic [LOCK_CNT_W-1:0]   lock_cnt;
    } dbg_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk domain and flags its edges.
// SYNC_STAGES must be at least 2 for metastability protection.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level  = r_sync[SYNC_STAGES-1];
    assign w_edge = level ^ r_hist;
    assign rise   = w_edge & level;
    assign fall   = w_edge & ~level;

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures high/low phase lengths of a slow asynchronous clock in clk cycles,
// reports each complete pair and flags lock once the pair stays stable.
module clock_ratio_detector
    import clock_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_in,
    output logic [COUNT_WIDTH-1:0] high_len,
    output logic [COUNT_WIDTH-1:0] low_len,
    output logic                   ratio_valid,
    output logic                   locked,
    output logic                   timeout,
    output dbg_t                   dbg
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [LOCK_CNT_W-1:0]  LOCK_MAX = LOCK_CNT_W'(LOCK_COUNT);

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_match;

    state_t                  r_state,       w_state;
    logic [COUNT_WIDTH-1:0]  r_cnt,         w_cnt;
    logic [COUNT_WIDTH-1:0]  r_high_len,    w_high_len;
    logic [COUNT_WIDTH-1:0]  r_low_len,     w_low_len;
    logic [COUNT_WIDTH-1:0]  r_prev_high,   w_prev_high;
    logic [COUNT_WIDTH-1:0]  r_prev_low,    w_prev_low;
    logic                    r_prev_valid,  w_prev_valid;
    logic                    r_have_high,   w_have_high;
    logic                    r_have_low,    w_have_low;
    logic [LOCK_CNT_W-1:0]   r_lock_cnt,    w_lock_cnt;
    logic                    r_ratio_valid, w_ratio_valid;
    logic                    r_locked,      w_locked;
    logic                    r_timeout,     w_timeout;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(clk_in),
        .level   (w_level),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_edge  = w_rise | w_fall;
    // On a rise the pair being completed is (last captured high, current count).
    assign w_match = r_prev_valid && (r_prev_high == r_high_len) && (r_prev_low == r_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_high_len    <= '0;
            r_low_len     <= '0;
            r_prev_high   <= '0;
            r_prev_low    <= '0;
            r_prev_valid  <= 1'b0;
            r_have_high   <= 1'b0;
            r_have_low    <= 1'b0;
            r_lock_cnt    <= '0;
            r_ratio_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_high_len    <= w_high_len;
            r_low_len     <= w_low_len;
            r_prev_high   <= w_prev_high;
            r_prev_low    <= w_prev_low;
            r_prev_valid  <= w_prev_valid;
            r_have_high   <= w_have_high;
            r_have_low    <= w_have_low;
            r_lock_cnt    <= w_lock_cnt;
            r_ratio_valid <= w_ratio_valid;
            r_locked      <= w_locked;
            r_timeout     <= w_timeout;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_high_len    = r_high_len;
        w_low_len     = r_low_len;
        w_prev_high   = r_prev_high;
        w_prev_low    = r_prev_low;
        w_prev_valid  = r_prev_valid;
        w_have_high   = r_have_high;
        w_have_low    = r_have_low;
        w_lock_cnt    = r_lock_cnt;
        w_ratio_valid = 1'b0;
        w_locked      = r_locked;
        w_timeout     = r_timeout;

        case (r_state)
            IDLE: begin
                // The first edge only aligns; the partial phase before it is dropped.
                if (w_edge) begin
                    w_cnt     = CNT_ONE;
                    w_state   = TRACK;
                    w_timeout = 1'b0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            TRACK: begin
                if (w_fall) begin
                    w_high_len  = r_cnt;
                    w_have_high = 1'b1;
                    w_cnt       = CNT_ONE;
                end else if (w_rise) begin
                    w_low_len  = r_cnt;
                    w_have_low = 1'b1;
                    w_cnt      = CNT_ONE;
                    if (r_have_high) begin
                        w_ratio_valid = 1'b1;
                        if (w_match) begin
                            w_lock_cnt = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt
                                                                  : r_lock_cnt + 1'b1;
                        end else begin
                            w_lock_cnt = '0;
                        end
                        w_prev_high  = r_high_len;
                        w_prev_low   = r_cnt;
                        w_prev_valid = 1'b1;
                        w_locked     = (w_lock_cnt == LOCK_MAX);
                    end
                end else if (r_cnt == CNT_MAX) begin
                    // Counter would overflow: the source stalled, drop alignment.
                    w_timeout    = 1'b1;
                    w_locked     = 1'b0;
                    w_lock_cnt   = '0;
                    w_have_high  = 1'b0;
                    w_have_low   = 1'b0;
                    w_prev_valid = 1'b0;
                    w_prev_high  = '0;
                    w_prev_low   = '0;
                    w_state      = IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign high_len      = r_high_len;
    assign low_len       = r_low_len;
    assign ratio_valid   = r_ratio_valid;
    assign locked        = r_locked;
    assign timeout       = r_timeout;
    assign dbg.state     = r_state;
    assign dbg.level     = w_level;
    assign dbg.have_high = r_have_high;
    assign dbg.have_low  = r_have_low;
    assign dbg.lock_cnt  = r_lock_cnt;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Bench for clock_ratio_detector: drives clk_in as phase sequences and checks
// every reported pair against a phase-level model of the measurement rules.
module tb_clock_ratio_detector;
    import clock_pkg::*;

    localparam int CW    = 4;
    localparam int LC    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int EXP_W = 17;

    logic          clk;
    logic          reset;
    logic          clk_in;
    logic [CW-1:0] high_len;
    logic [CW-1:0] low_len;
    logic          ratio_valid;
    logic          locked;
    logic          timeout;
    dbg_t          dbg;

    int n_checks;
    int n_pass;
    int cyc;

    clock_ratio_detector #(
        .COUNT_WIDTH(CW),
        .SYNC_STAGES(2),
        .LOCK_COUNT (LC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_in     (clk_in),
        .high_len   (high_len),
        .low_len    (low_len),
        .ratio_valid(ratio_valid),
        .locked     (locked),
        .timeout    (timeout),
        .dbg        (dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Works on driven edges only: a phase is the clk count between two edges.
    logic              m_lvl;
    bit                m_aligned;
    int                m_last_edge;
    bit                m_have_h;
    int                m_high;
    logic [CW-1:0]     m_high_out;
    logic [CW-1:0]     m_low_out;
    bit                m_locked;
    logic [2*CW-1:0]   m_hist[$];
    bit                m_pv;
    int                m_last_pulse;
    int                m_n_exp;
    logic [EXP_W-1:0]  exp_q[$];

    task automatic model_reset();
        m_lvl      = 1'b0;
        m_aligned  = 0;
        m_have_h   = 0;
        m_high     = 0;
        m_high_out = '0;
        m_low_out  = '0;
        m_locked   = 0;
        m_pv       = 0;
        m_hist.delete();
        exp_q.delete();
    endtask

    task automatic model_edge(input logic new_lvl);
        int              dur;
        bit              all_eq;
        logic [2*CW-1:0] last;
        int              gap;
        dur         = cyc - m_last_edge;
        m_last_edge = cyc;
        if (!m_aligned) begin
            m_aligned = 1;
        end else if (dur > CMAX) begin
            // Source stalled longer than the counter range: start over on this edge.
            m_have_h = 0;
            m_pv     = 0;
            m_locked = 0;
            m_hist.delete();
        end else if (!new_lvl) begin
            m_high     = dur;
            m_high_out = CW'(dur);
            m_have_h   = 1;
        end else begin
            m_low_out = CW'(dur);
            if (m_have_h) begin
                m_hist.push_back({CW'(m_high), CW'(dur)});
                last   = m_hist[m_hist.size()-1];
                all_eq = (m_hist.size() >= LC + 1);
                if (all_eq) begin
                    for (int i = 1; i <= LC; i++)
                        if (m_hist[m_hist.size()-1-i] != last) all_eq = 0;
                end
                m_locked     = all_eq;
                gap          = m_pv ? (cyc - m_last_pulse) : 0;
                m_pv         = 1;
                m_last_pulse = cyc;
                m_n_exp++;
                exp_q.push_back({8'(gap), m_locked, CW'(m_high), CW'(dur)});
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_phase(input logic lvl, input int len);
        @(negedge clk);
        if (lvl !== m_lvl) model_edge(lvl);
        m_lvl  = lvl;
        clk_in = lvl;
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic drive_period(input int h, input int l);
        drive_phase(1'b1, h);
        drive_phase(1'b0, l);
    endtask

    task automatic flush();
        drive_phase(1'b1, 6);
        drive_phase(1'b0, 6);
    endtask

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] mon_e;
    int               mon_last;
    int               n_seen;
    bit               seen_timeout;

    initial begin
        n_seen       = 0;
        mon_last     = 0;
        seen_timeout = 0;
    end

    always @(negedge clk) begin
        if (!reset && timeout) seen_timeout = 1;
        if (!reset && ratio_valid) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got pulse high=%0d low=%0d, expected none", high_len, low_len);
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (high_len !== mon_e[2*CW-1:CW])
                    $display("FAIL pair_high: got %0d expected %0d", high_len, mon_e[2*CW-1:CW]);
                else n_pass++;
                n_checks++;
                if (low_len !== mon_e[CW-1:0])
                    $display("FAIL pair_low: got %0d expected %0d", low_len, mon_e[CW-1:0]);
                else n_pass++;
                n_checks++;
                if (locked !== mon_e[2*CW])
                    $display("FAIL pair_locked: got %0b expected %0b", locked, mon_e[2*CW]);
                else n_pass++;
                if (mon_e[EXP_W-1:2*CW+1] != 8'd0) begin
                    n_checks++;
                    if (cyc - mon_last != int'(mon_e[EXP_W-1:2*CW+1]))
                        $display("FAIL pulse_gap: got %0d expected %0d", cyc - mon_last, mon_e[EXP_W-1:2*CW+1]);
                    else n_pass++;
                end
            end
            mon_last = cyc;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset  = 1'b1;
        clk_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({high_len, low_len, ratio_valid, locked, timeout} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {high_len, low_len, ratio_valid, locked, timeout});
        else n_pass++;
        n_checks++;
        if (dbg.state !== IDLE || dbg.lock_cnt !== '0)
            $display("FAIL reset_state: got %0d/%0d expected IDLE/0", dbg.state, dbg.lock_cnt);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_div3();
        repeat (6) drive_period(3, 3);
        flush();
        n_checks++;
        if (locked !== 1'b1 || locked !== m_locked)
            $display("FAIL div3_locked: got %0b expected 1", locked);
        else n_pass++;
        n_checks++;
        if (n_seen !== m_n_exp)
            $display("FAIL div3_pulses: got %0d expected %0d", n_seen, m_n_exp);
        else n_pass++;
    endtask

    task automatic test_asym();
        repeat (7) drive_period(5, 2);
        flush();
        n_checks++;
        if (locked !== m_locked)
            $display("FAIL asym_locked: got %0b expected %0b", locked, m_locked);
        else n_pass++;
        n_checks++;
        if (high_len !== m_high_out || low_len !== m_low_out)
            $display("FAIL asym_lens: got %0d/%0d expected %0d/%0d", high_len, low_len, m_high_out, m_low_out);
        else n_pass++;
    endtask

    task automatic test_period_change();
        repeat (7) drive_period(3, 3);
        drive_phase(1'b1, 5);
        n_checks++;
        if (locked !== 1'b1)
            $display("FAIL change_prelock: got %0b expected 1", locked);
        else n_pass++;
        drive_phase(1'b0, 3);
        repeat (6) drive_period(4, 4);
        flush();
        n_checks++;
        if (n_seen !== m_n_exp || exp_q.size() != 0)
            $display("FAIL change_pulses: got %0d expected %0d", n_seen, m_n_exp);
        else n_pass++;
    endtask

    task automatic test_timeout();
        drive_phase(1'b1, 4);
        drive_phase(1'b0, 30);
        n_checks++;
        if (timeout !== 1'b1 || locked !== 1'b0)
            $display("FAIL timeout_set: got %0b/%0b expected 1/0", timeout, locked);
        else n_pass++;
        n_checks++;
        if (dbg.state !== IDLE || high_len !== m_high_out)
            $display("FAIL timeout_hold: got state %0d high %0d expected IDLE high %0d", dbg.state, high_len, m_high_out);
        else n_pass++;
        drive_phase(1'b1, 6);
        n_checks++;
        if (timeout !== 1'b0 || dbg.state !== TRACK)
            $display("FAIL timeout_clear: got %0b/%0d expected 0/TRACK", timeout, dbg.state);
        else n_pass++;
        repeat (5) drive_period(3, 3);
        flush();
        n_checks++;
        if (n_seen !== m_n_exp || exp_q.size() != 0)
            $display("FAIL timeout_pulses: got %0d expected %0d", n_seen, m_n_exp);
        else n_pass++;
    endtask

    task automatic test_max_phase();
        seen_timeout = 0;
        drive_period(15, 15);
        drive_period(15, 15);
        drive_period(3, 3);
        flush();
        n_checks++;
        if (seen_timeout !== 1'b0)
            $display("FAIL max_no_timeout: got %0b expected 0", seen_timeout);
        else n_pass++;
        n_checks++;
        if (n_seen !== m_n_exp || exp_q.size() != 0)
            $display("FAIL max_pulses: got %0d expected %0d", n_seen, m_n_exp);
        else n_pass++;
    endtask

    task automatic test_min_phase();
        repeat (7) drive_period(1, 1);
        flush();
        n_checks++;
        if (n_seen !== m_n_exp || exp_q.size() != 0)
            $display("FAIL min_pulses: got %0d expected %0d", n_seen, m_n_exp);
        else n_pass++;
    endtask

    task automatic test_random();
        int h;
        int l;
        int reps;
        for (int g = 0; g < 14; g++) begin
            h    = $urandom_range(1, CMAX);
            l    = $urandom_range(1, CMAX);
            reps = $urandom_range(1, 7);
            if ($urandom_range(0, 7) == 0) l = $urandom_range(CMAX + 1, CMAX + 5);
            for (int r = 0; r < reps; r++) drive_period(h, l);
        end
        flush();
        n_checks++;
        if (n_seen !== m_n_exp || exp_q.size() != 0)
            $display("FAIL random_pulses: got %0d expected %0d", n_seen, m_n_exp);
        else n_pass++;
        n_checks++;
        if (locked !== m_locked || timeout !== 1'b0)
            $display("FAIL random_status: got %0b/%0b expected %0b/0", locked, timeout, m_locked);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        repeat (7) drive_period(3, 3);
        drive_phase(1'b1, 1);
        repeat (5) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1)
            $display("FAIL mid_prelock: got %0b expected 1", locked);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({high_len, low_len, ratio_valid, locked, timeout} !== '0 || dbg.state !== IDLE)
            $display("FAIL mid_reset_outputs: got %h expected 0", {high_len, low_len, ratio_valid, locked, timeout});
        else n_pass++;
        clk_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) drive_period(4, 2);
        flush();
        n_checks++;
        if (locked !== 1'b0 || n_seen !== m_n_exp || exp_q.size() != 0)
            $display("FAIL mid_post: got locked %0b pulses %0d expected 0/%0d", locked, n_seen, m_n_exp);
        else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        m_n_exp     = 0;
        m_last_edge = 0;
        m_last_pulse = 0;
        reset       = 1'b1;
        clk_in      = 1'b0;
        test_reset();
        test_div3();
        test_asym();
        test_period_change();
        test_timeout();
        test_max_phase();
        test_min_phase();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
